// File: rtl/lsu_mem_ctrl_if.sv
// CPU request/response and RAM wrapper signals for the load/store front-end.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_rden;
   logic        ram_wren;
   logic [31:0] ram_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3,
      input  req_addr, req_wdata,
      input  rsp_ready, ram_rdata,
      output req_ready, rsp_valid,
      output rsp_rdata, rsp_err,
      output ram_addr, ram_wdata,
      output ram_rden, ram_wren
   );

   modport master (
      output req_valid, req_we, req_funct3,
      output req_addr, req_wdata,
      output rsp_ready, ram_rdata,
      input  req_ready, rsp_valid,
      input  rsp_rdata, rsp_err,
      input  ram_addr, ram_wdata,
      input  ram_rden, ram_wren
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end: one request at a time, sub-word stores
// become read-modify-write, loads are aligned and extended.
module lsu_mem_ctrl #(
   parameter int WORD_AW = 9
) (
   input  logic          m_clock,
   input  logic          p_reset,
   lsu_mem_ctrl_if.slave bus
);

   localparam int AW = WORD_AW + 2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RDW,
      WR,
      RESP
   } state_e;

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.req_addr[31:AW];

   function automatic logic acc_err(
      input logic       we,
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic e;
      e = 1'b1;
      unique case (f3)
         3'b000:  e = 1'b0;
         3'b001:  e = a[0];
         3'b010:  e = |a;
         3'b100:  e = we;
         3'b101:  e = we | a[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] ld_fmt(
      input logic [2:0]  f3,
      input logic [1:0]  a,
      input logic [31:0] w
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'h0} +: 16];
      r = w;
      unique case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'h0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Only the addressed lane is replaced; the rest is the old RAM word.
   function automatic logic [31:0] st_merge(
      input logic [2:0]  f3,
      input logic [1:0]  a,
      input logic [31:0] old,
      input logic [31:0] wd
   );
      logic [31:0] r;
      r = old;
      if (f3 == 3'b000) begin
         r[{a, 3'b000} +: 8] = wd[7:0];
      end else if (f3 == 3'b001) begin
         r[{a[1], 4'h0} +: 16] = wd[15:0];
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               addr_d  = bus.req_addr[AW-1:0];
               wdata_d = bus.req_wdata;
               rdata_d = '0;
               err_d   = acc_err(bus.req_we,
                                 bus.req_funct3,
                                 bus.req_addr[1:0]);
               if (err_d) begin
                  state_d = RESP;
               end else if (bus.req_we &&
                            bus.req_funct3 == 3'b010) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: state_d = RDW;
         RDW: begin
            if (we_q) begin
               wdata_d = st_merge(f3_q, addr_q[1:0],
                                  bus.ram_rdata, wdata_q);
               state_d = WR;
            end else begin
               rdata_d = ld_fmt(f3_q, addr_q[1:0],
                                bus.ram_rdata);
               state_d = RESP;
            end
         end
         WR: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.ram_rden  = (state_q == RD);
   assign bus.ram_wren  = (state_q == WR);
   assign bus.ram_wdata = wdata_q;
   assign bus.ram_addr  = {{(32-WORD_AW){1'b0}},
                           addr_q[AW-1:2]};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a small synchronous RAM model.
module tb_lsu_mem_ctrl;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   logic mem_clr;
   int   checks;
   int   failures;

   exp_t        exp_q[$];
   logic [31:0] mem [0:511];
   logic [31:0] ram_q;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl #(.WORD_AW(9)) dut (
      .m_clock (clk),
      .p_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 512; i++) mem[i] <= '0;
      end else begin
         if (bus.ram_wren) mem[bus.ram_addr[8:0]] <= bus.ram_wdata;
         if (bus.ram_rden) ram_q <= mem[bus.ram_addr[8:0]];
      end
   end
   assign bus.ram_rdata = ram_q;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_rdata"}, bus.rsp_rdata, e.data);
            check({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   task automatic do_req(input string tag,
                         input logic we,
                         input logic [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [31:0] ed,
                         input logic ee,
                         input int e_rd,
                         input int e_wr,
                         input int e_rsp,
                         input logic [31:0] ea,
                         input int hold);
      int  rd_at, wr_at, rsp_at;
      bit  done;
      rd_at = 0; wr_at = 0; rsp_at = 0; done = 0;
      bus.rsp_ready  = (hold == 0);
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      exp_q.push_back('{tag, ed, ee});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 20 && !done; k++) begin
         check({tag, "_excl"}, 32'(bus.ram_rden & bus.ram_wren), 32'd0);
         if (bus.ram_rden && rd_at == 0) begin
            rd_at = k;
            check({tag, "_rd_addr"}, bus.ram_addr, ea);
         end
         if (bus.ram_wren && wr_at == 0) begin
            wr_at = k;
            check({tag, "_wr_addr"}, bus.ram_addr, ea);
         end
         if (bus.rsp_valid) begin
            rsp_at = k;
            done = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      check({tag, "_rd_cyc"}, 32'(rd_at), 32'(e_rd));
      check({tag, "_wr_cyc"}, 32'(wr_at), 32'(e_wr));
      check({tag, "_rsp_cyc"}, 32'(rsp_at), 32'(e_rsp));
      for (int h = 0; h < hold; h++) begin
         if (h == 0) begin
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h20;
            bus.req_wdata  = 32'h55;
            bus.req_valid  = 1'b1;
         end
         check({tag, "_bp_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, "_bp_rdata"}, bus.rsp_rdata, ed);
         check({tag, "_bp_ready"}, 32'(bus.req_ready), 32'd0);
         check({tag, "_bp_wren"}, 32'(bus.ram_wren), 32'd0);
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   logic [31:0] saved;

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      mem_clr = 1'b1;
      ram_q = '0;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      #2;
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rden", 32'(bus.ram_rden), 32'd0);
      check("rst_wren", 32'(bus.ram_wren), 32'd0);
      check("rst_addr", bus.ram_addr, 32'd0);
      @(posedge clk); #1;
      mem_clr = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_req("sw", 1, 3'b010, 32'h10, 32'hDEADBEEF,
             32'h0, 0, 0, 1, 2, 32'd4, 0);
      check("mem_sw", mem[4], 32'hDEADBEEF);
      do_req("lw", 0, 3'b010, 32'h10, 32'h0,
             32'hDEADBEEF, 0, 1, 0, 3, 32'd4, 0);
      do_req("sb", 1, 3'b000, 32'h11, 32'h80,
             32'h0, 0, 1, 3, 4, 32'd4, 0);
      check("mem_sb", mem[4], 32'hDEAD80EF);
      do_req("lb", 0, 3'b000, 32'h11, 32'h0,
             32'hFFFFFF80, 0, 1, 0, 3, 32'd4, 0);
      do_req("lbu", 0, 3'b100, 32'h11, 32'h0,
             32'h00000080, 0, 1, 0, 3, 32'd4, 0);
      do_req("sh", 1, 3'b001, 32'h12, 32'h1234,
             32'h0, 0, 1, 3, 4, 32'd4, 0);
      check("mem_sh", mem[4], 32'h123480EF);
      do_req("lh", 0, 3'b001, 32'h12, 32'h0,
             32'h00001234, 0, 1, 0, 3, 32'd4, 0);
      do_req("lhu", 0, 3'b101, 32'h10, 32'h0,
             32'h000080EF, 0, 1, 0, 3, 32'd4, 0);
      do_req("err_lw13", 0, 3'b010, 32'h13, 32'h0,
             32'h0, 1, 0, 0, 1, 32'd0, 0);
      do_req("err_sh11", 1, 3'b001, 32'h11, 32'hFFFF,
             32'h0, 1, 0, 0, 1, 32'd0, 0);
      do_req("err_f011", 0, 3'b011, 32'h10, 32'h0,
             32'h0, 1, 0, 0, 1, 32'd0, 0);
      do_req("err_sbu", 1, 3'b100, 32'h10, 32'h0,
             32'h0, 1, 0, 0, 1, 32'd0, 0);
      check("mem_err", mem[4], 32'h123480EF);
      do_req("sw_wrap", 1, 3'b010, 32'h810, 32'hCAFEF00D,
             32'h0, 0, 0, 1, 2, 32'd4, 0);
      check("mem_wrap", mem[4], 32'hCAFEF00D);
      do_req("lw_bp", 0, 3'b010, 32'h10, 32'h0,
             32'hCAFEF00D, 0, 1, 0, 3, 32'd4, 5);
      check("mem_ignored", mem[8], 32'h0);

      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h11;
      bus.req_wdata  = 32'h0;
      bus.req_valid  = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_addr", bus.ram_addr, 32'd4);
      saved = mem[4];
      rst_n = 1'b0;
      #1;
      check("mid_ready", 32'(bus.req_ready), 32'd1);
      check("mid_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rden", 32'(bus.ram_rden), 32'd0);
      check("mid_wren", 32'(bus.ram_wren), 32'd0);
      check("mid_addr0", bus.ram_addr, 32'd0);
      check("mid_wdata", bus.ram_wdata, 32'd0);
      check("mid_rdata", bus.rsp_rdata, 32'd0);
      check("mid_err", 32'(bus.rsp_err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("post_wren", 32'(bus.ram_wren), 32'd0);
         check("post_ready", 32'(bus.req_ready), 32'd1);
         @(posedge clk); #1;
      end
      check("mid_mem", mem[4], saved);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
